dmem_access_ctrl: RTL and testbench

Data-memory access controller for the MEM stage of the 5-stage RISC-V pipeline. It watches the control and data outputs of the EX/MEM pipeline register, runs a req/ack handshake with a variable-latency data memory, and drives the pipeline-wide `stall`. It also derives the branch-taken `flush` and PC redirect, with a timeout watchdog and a stall-cycle performance counter.

---
 rtl/dmem_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory req/ack controller: stalls the pipeline for 2+N cycles per access (N = memory wait cycles),
// then releases it for one DONE cycle. Also derives the branch flush/redirect, the access watchdog and the stall counter.
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        branch,
    input  logic        zero_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        timeout_err,
    output logic [31:0] perf_stall_cycles
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic          timeout_err_q, timeout_err_d;
    logic [31:0]   perf_q, perf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          access;
    logic          stall_c;

    assign access  = mem_read | mem_write;
    assign stall_c = ((state_q == IDLE) && access) || (state_q == BUSY);

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                if (access) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = mem_write;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (dmem_ack && req_q) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d       = dmem_rdata;
                        rdata_valid_d = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    // Abort: a read still reports completion, with zero data, so the load retires.
                    req_d         = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                    if (!we_q) begin
                        rdata_d       = '0;
                        rdata_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        perf_d = perf_q;
        if (stall_c && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
            perf_q        <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            timeout_err_q <= timeout_err_d;
            perf_q        <= perf_d;
            cnt_q         <= cnt_d;
        end
    end

    assign dmem_req          = req_q;
    assign dmem_we           = we_q;
    assign dmem_addr         = addr_q;
    assign dmem_wdata        = wdata_q;
    assign stall             = stall_c;
    // DONE is excluded so a branch never shares the release cycle of a serviced access.
    assign flush             = branch & zero_ctrl & ~stall_c & (state_q != DONE);
    assign pc_redirect       = flush;
    assign rdata             = rdata_q;
    assign rdata_valid       = rdata_valid_q;
    assign timeout_err       = timeout_err_q;
    assign perf_stall_cycles = perf_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 4-cycle watchdog.
module tb_dmem_access_ctrl;

    logic        clock;
    logic        reset;
    logic        mem_read, mem_write, branch, zero_ctrl;
    logic [31:0] addr, wdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall, flush, pc_redirect;
    logic [31:0] rdata;
    logic        rdata_valid, timeout_err;
    logic [31:0] perf_stall_cycles;

    int tests_run = 0;
    int tests_failed = 0;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .zero_ctrl(zero_ctrl),
        .addr(addr), .wdata(wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .flush(flush), .pc_redirect(pc_redirect),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .timeout_err(timeout_err), .perf_stall_cycles(perf_stall_cycles)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then changed and
    // outputs sampled well clear of the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        mem_read = 0; mem_write = 0; branch = 0; zero_ctrl = 0;
        addr = '0; wdata = '0; dmem_ack = 0; dmem_rdata = '0;
        #12;
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_stall", stall, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rdata_valid, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_perf", perf_stall_cycles, 0);
        @(negedge clock) reset = 1'b0;
        step();

        // Load, ack on first req cycle
        mem_read = 1; addr = 32'h100; #1;
        chk("ld_idle_stall", stall, 1);
        chk("ld_idle_req", dmem_req, 0);
        step();
        dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; #1;
        chk("ld_busy_req", dmem_req, 1);
        chk("ld_busy_we", dmem_we, 0);
        chk("ld_busy_addr", dmem_addr, 32'h100);
        chk("ld_busy_stall", stall, 1);
        step();
        dmem_ack = 0; #1;
        chk("ld_done_stall", stall, 0);
        chk("ld_done_req", dmem_req, 0);
        chk("ld_done_rdata", rdata, 32'hDEADBEEF);
        chk("ld_done_rvalid", rdata_valid, 1);
        chk("ld_done_perf", perf_stall_cycles, 2);
        step();
        mem_read = 0; #1;
        chk("ld_idle2_rvalid", rdata_valid, 0);
        chk("ld_idle2_stall", stall, 0);

        // Ack while idle must be ignored
        dmem_ack = 1; dmem_rdata = 32'h5555AAAA;
        step();
        dmem_ack = 0; #1;
        chk("idle_ack_rvalid", rdata_valid, 0);
        chk("idle_ack_rdata", rdata, 32'hDEADBEEF);
        chk("idle_ack_req", dmem_req, 0);

        // Store, 3 wait cycles
        mem_write = 1; addr = 32'h40; wdata = 32'h12345678; #1;
        chk("st_idle_stall", stall, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_wait_req", dmem_req, 1);
            chk("st_wait_stall", stall, 1);
        end
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 32'h40);
        chk("st_wdata", dmem_wdata, 32'h12345678);
        step();
        dmem_ack = 1; dmem_rdata = 32'hFFFF0000; #1;
        chk("st_ack_stall", stall, 1);
        step();
        dmem_ack = 0; #1;
        chk("st_done_stall", stall, 0);
        chk("st_done_rvalid", rdata_valid, 0);
        chk("st_done_rdata", rdata, 32'hDEADBEEF);
        chk("st_done_perf", perf_stall_cycles, 7);
        step();
        mem_write = 0; #1;
        chk("st_idle2_rvalid", rdata_valid, 0);

        // Timeout on a read that is never acked
        mem_read = 1; addr = 32'h200; #1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_req_high", dmem_req, 1);
            chk("to_terr_low", timeout_err, 0);
        end
        step();
        chk("to_done_req", dmem_req, 0);
        chk("to_done_terr", timeout_err, 1);
        chk("to_done_rdata", rdata, 0);
        chk("to_done_rvalid", rdata_valid, 1);
        chk("to_done_stall", stall, 0);
        chk("to_done_perf", perf_stall_cycles, 12);
        step();
        mem_read = 0; #1;
        chk("to_idle_terr", timeout_err, 1);
        chk("to_idle_rvalid", rdata_valid, 0);
        chk("to_idle_stall", stall, 0);

        // Branch taken / not taken
        branch = 1; zero_ctrl = 1; #1;
        chk("br_flush", flush, 1);
        chk("br_redirect", pc_redirect, 1);
        chk("br_stall", stall, 0);
        zero_ctrl = 0; #1;
        chk("brnt_flush", flush, 0);
        chk("brnt_redirect", pc_redirect, 0);

        // Illegal branch + read in the same entry
        zero_ctrl = 1; mem_read = 1; addr = 32'h300; #1;
        chk("ill_idle_flush", flush, 0);
        chk("ill_idle_stall", stall, 1);
        step();
        dmem_ack = 1; dmem_rdata = 32'hCAFEF00D; #1;
        chk("ill_busy_flush", flush, 0);
        chk("ill_busy_addr", dmem_addr, 32'h300);
        step();
        dmem_ack = 0; #1;
        chk("ill_done_flush", flush, 0);
        chk("ill_done_rdata", rdata, 32'hCAFEF00D);
        chk("ill_done_rvalid", rdata_valid, 1);
        chk("ill_done_perf", perf_stall_cycles, 14);
        step();
        branch = 0; zero_ctrl = 0; mem_read = 0; #1;
        chk("ill_terr_sticky", timeout_err, 1);

        // Reset in the middle of an access
        mem_read = 1; addr = 32'h400;
        step();
        chk("mrst_busy_req", dmem_req, 1);
        mem_read = 0; reset = 1; #1;
        chk("mrst_req", dmem_req, 0);
        chk("mrst_addr", dmem_addr, 0);
        chk("mrst_rdata", rdata, 0);
        chk("mrst_terr", timeout_err, 0);
        chk("mrst_perf", perf_stall_cycles, 0);
        chk("mrst_stall", stall, 0);
        @(negedge clock) reset = 0;
        step();
        mem_read = 1; addr = 32'h500; #1;
        step();
        dmem_ack = 1; dmem_rdata = 32'h0BADC0DE; #1;
        chk("post_busy_addr", dmem_addr, 32'h500);
        step();
        dmem_ack = 0; #1;
        chk("post_done_rdata", rdata, 32'h0BADC0DE);
        chk("post_done_rvalid", rdata_valid, 1);
        chk("post_done_perf", perf_stall_cycles, 2);
        step();
        mem_read = 0; #1;
        chk("post_idle_stall", stall, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
